// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a parallel word out MSB-first a programmable
// number of times, idle-high between repetitions, and counts emitted 0->1 transitions.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4,
  parameter int GAP   = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [REP_W-1:0] rep,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hits
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0]    BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0]    GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [CNT_W-1:0] HITS_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP, ST_DONE} state_t;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   shreg_r, shreg_s;
  logic [WIDTH-1:0]   word_r, word_s;
  logic [REP_W-1:0]   rep_left_r, rep_left_s;
  logic [BW-1:0]      bit_idx_r, bit_idx_s;
  logic [GW-1:0]      gap_cnt_r, gap_cnt_s;
  logic               prev_bit_r, prev_bit_s;
  logic [CNT_W-1:0]   hits_r, hits_s;
  logic               sout_r, sout_s;
  logic               sout_valid_r, sout_valid_s;
  logic               done_r, done_s;
  logic               busy_r, busy_s;
  logic               din_ready_r, din_ready_s;

  // Saturating count of a rising transition on the line.
  function automatic logic [CNT_W-1:0] next_hits(input logic [CNT_W-1:0] h,
                                                 input logic b, input logic p);
    if (b && !p && (h != HITS_MAX)) begin
      return h + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return h;
    end
  endfunction

  // Next-state and next-output logic; outputs are computed for the cycle after the edge.
  always_comb begin
    state_s      = state_r;
    shreg_s      = shreg_r;
    word_s       = word_r;
    rep_left_s   = rep_left_r;
    bit_idx_s    = bit_idx_r;
    gap_cnt_s    = gap_cnt_r;
    prev_bit_s   = prev_bit_r;
    hits_s       = hits_r;
    sout_s       = 1'b1;
    sout_valid_s = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (din_valid) begin
          state_s      = ST_SHIFT;
          word_s       = din;
          shreg_s      = din << 1;
          sout_s       = din[WIDTH-1];
          sout_valid_s = 1'b1;
          rep_left_s   = (rep == '0) ? {{(REP_W-1){1'b0}}, 1'b1} : rep;
          bit_idx_s    = '0;
          hits_s       = '0;
          prev_bit_s   = din[WIDTH-1];
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bit_idx_r == BIT_LAST) begin
          if (rep_left_r > {{(REP_W-1){1'b0}}, 1'b1}) begin
            rep_left_s = rep_left_r - {{(REP_W-1){1'b0}}, 1'b1};
            shreg_s    = word_r;
            bit_idx_s  = '0;
            if (GAP > 0) begin
              state_s    = ST_GAP;
              gap_cnt_s  = '0;
              prev_bit_s = 1'b1;
            end else begin
              // No bubble: the next repetition's MSB goes out immediately.
              sout_s       = word_r[WIDTH-1];
              sout_valid_s = 1'b1;
              shreg_s      = word_r << 1;
              hits_s       = next_hits(hits_r, word_r[WIDTH-1], prev_bit_r);
              prev_bit_s   = word_r[WIDTH-1];
            end
          end else begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end
        end else begin
          sout_s       = shreg_r[WIDTH-1];
          sout_valid_s = 1'b1;
          shreg_s      = shreg_r << 1;
          bit_idx_s    = bit_idx_r + {{(BW-1){1'b0}}, 1'b1};
          hits_s       = next_hits(hits_r, shreg_r[WIDTH-1], prev_bit_r);
          prev_bit_s   = shreg_r[WIDTH-1];
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s      = ST_SHIFT;
          sout_s       = shreg_r[WIDTH-1];
          sout_valid_s = 1'b1;
          shreg_s      = shreg_r << 1;
          hits_s       = next_hits(hits_r, shreg_r[WIDTH-1], prev_bit_r);
          prev_bit_s   = shreg_r[WIDTH-1];
        end else begin
          gap_cnt_s = gap_cnt_r + {{(GW-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s      = (state_s != ST_IDLE);
    din_ready_s = (state_s == ST_IDLE);
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      shreg_r      <= '0;
      word_r       <= '0;
      rep_left_r   <= '0;
      bit_idx_r    <= '0;
      gap_cnt_r    <= '0;
      prev_bit_r   <= 1'b1;
      hits_r       <= '0;
      sout_r       <= 1'b1;
      sout_valid_r <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      din_ready_r  <= 1'b1;
    end else begin
      state_r      <= state_s;
      shreg_r      <= shreg_s;
      word_r       <= word_s;
      rep_left_r   <= rep_left_s;
      bit_idx_r    <= bit_idx_s;
      gap_cnt_r    <= gap_cnt_s;
      prev_bit_r   <= prev_bit_s;
      hits_r       <= hits_s;
      sout_r       <= sout_s;
      sout_valid_r <= sout_valid_s;
      done_r       <= done_s;
      busy_r       <= busy_s;
      din_ready_r  <= din_ready_s;
    end
  end

  assign din_ready  = din_ready_r;
  assign sout       = sout_r;
  assign sout_valid = sout_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign hits       = hits_r;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: three parameterisations driven by shared stimulus,
// each compared cycle by cycle against a frame-level expectation queue.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [3:0] rep;
  logic       din_valid;

  logic       rdy0, so0, sv0, bz0, dn0;
  logic       rdy1, so1, sv1, bz1, dn1;
  logic       rdy2, so2, sv2, bz2, dn2;
  logic [7:0] h0, h1;
  logic [1:0] h2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .REP_W(4), .GAP(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .din(din), .rep(rep), .din_valid(din_valid), .din_ready(rdy0),
    .sout(so0), .sout_valid(sv0), .busy(bz0), .done(dn0), .hits(h0));
  serial_pattern_tx #(.WIDTH(8), .REP_W(4), .GAP(0), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .din(din), .rep(rep), .din_valid(din_valid), .din_ready(rdy1),
    .sout(so1), .sout_valid(sv1), .busy(bz1), .done(dn1), .hits(h1));
  serial_pattern_tx #(.WIDTH(8), .REP_W(4), .GAP(2), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .din(din), .rep(rep), .din_valid(din_valid), .din_ready(rdy2),
    .sout(so2), .sout_valid(sv2), .busy(bz2), .done(dn2), .hits(h2));

  typedef struct {
    logic sout;
    logic valid;
    logic done;
    logic busy;
    logic ready;
    int   hits;
  } exp_t;

  exp_t q [3][$];
  exp_t disp [3];
  int   gap_p [3] = '{1, 0, 2};
  int   hmax  [3] = '{255, 255, 3};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t idle_entry(input int h);
    exp_t e;
    e.sout = 1'b1; e.valid = 1'b0; e.done = 1'b0; e.busy = 1'b0; e.ready = 1'b1; e.hits = h;
    return e;
  endfunction

  // Expand a whole frame into the per-cycle line picture a receiver would see.
  function automatic void build(input int k, input logic [7:0] w, input int r);
    int   reps;
    int   h;
    logic prev;
    exp_t e;
    reps = (r == 0) ? 1 : r;
    h = 0;
    prev = 1'b1;
    for (int j = 0; j < reps; j++) begin
      if (j > 0) begin
        for (int g = 0; g < gap_p[k]; g++) begin
          prev = 1'b1;
          e.sout = 1'b1; e.valid = 1'b0; e.done = 1'b0; e.busy = 1'b1; e.ready = 1'b0; e.hits = h;
          q[k].push_back(e);
        end
      end
      for (int b = 7; b >= 0; b--) begin
        if (w[b] && !prev && h < hmax[k]) h++;
        prev = w[b];
        e.sout = w[b]; e.valid = 1'b1; e.done = 1'b0; e.busy = 1'b1; e.ready = 1'b0; e.hits = h;
        q[k].push_back(e);
      end
    end
    e.sout = 1'b1; e.valid = 1'b0; e.done = 1'b1; e.busy = 1'b1; e.ready = 1'b0; e.hits = h;
    q[k].push_back(e);
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (disp[k].ready && din_valid) begin
        build(k, din, int'(rep));
        disp[k] = q[k].pop_front();
      end else if (q[k].size() > 0) begin
        disp[k] = q[k].pop_front();
      end else begin
        disp[k] = idle_entry(disp[k].hits);
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      disp[k] = idle_entry(0);
    end
  endtask

  task automatic check_inst(input int k, input logic so, input logic sv, input logic dn,
                            input logic bz, input logic rd, input int h);
    check_eq($sformatf("u%0d sout", k),       int'(so), int'(disp[k].sout));
    check_eq($sformatf("u%0d sout_valid", k), int'(sv), int'(disp[k].valid));
    check_eq($sformatf("u%0d done", k),       int'(dn), int'(disp[k].done));
    check_eq($sformatf("u%0d busy", k),       int'(bz), int'(disp[k].busy));
    check_eq($sformatf("u%0d din_ready", k),  int'(rd), int'(disp[k].ready));
    check_eq($sformatf("u%0d hits", k),       h,        disp[k].hits);
  endtask

  task automatic check_all();
    check_inst(0, so0, sv0, dn0, bz0, rdy0, int'(h0));
    check_inst(1, so1, sv1, dn1, bz1, rdy1, int'(h1));
    check_inst(2, so2, sv2, dn2, bz2, rdy2, int'(h2));
  endtask

  // One clock: drive at the falling edge, advance model at the rising edge, check at the next fall.
  task automatic cycle(input logic v, input logic [7:0] d, input logic [3:0] r);
    din_valid = v;
    din = d;
    rep = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    din = 8'h00;
    rep = 4'd0;
    din_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    cycle(1'b1, 8'h55, 4'd1);
    repeat (12) cycle(1'b0, 8'h00, 4'd0);
    check_eq("h55 hits", int'(h0), 4);
    cycle(1'b1, 8'h0F, 4'd2);
    repeat (24) cycle(1'b0, 8'h00, 4'd0);
    check_eq("h0F gap0 hits", int'(h1), 2);
    cycle(1'b1, 8'h80, 4'd0);
    repeat (12) cycle(1'b0, 8'h00, 4'd0);
    check_eq("h80 hits", int'(h0), 0);
    cycle(1'b1, 8'h55, 4'd2);
    repeat (24) cycle(1'b0, 8'h00, 4'd0);
    check_eq("sat hits", int'(h2), 3);

    for (int i = 0; i < 80; i++) cycle(1'b1, 8'($urandom), 4'($urandom_range(0, 3)));
    repeat (40) cycle(1'b0, 8'h00, 4'd0);

    // Abandon a frame while bit 3 is on the line.
    cycle(1'b1, 8'h55, 4'd1);
    repeat (3) cycle(1'b0, 8'h00, 4'd0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;
    repeat (12) cycle(1'b0, 8'h00, 4'd0);

    for (int i = 0; i < 700; i++) begin
      cycle(($urandom_range(0, 3) == 0), 8'($urandom), 4'($urandom_range(0, 4)));
    end
    repeat (40) cycle(1'b0, 8'h00, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
